// File: rtl/uart_receptor_if.sv
// Receive-side output bundle of the UART receiver: received word, done strobe and framing flag.
interface uart_receptor_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] o_dout;
  logic              o_rx_done_tick;
  logic              o_frame_error;

  modport master (
    output o_dout,
    output o_rx_done_tick,
    output o_frame_error
  );

  modport slave (
    input o_dout,
    input o_rx_done_tick,
    input o_frame_error
  );
endinterface

// File: rtl/uart_receptor.sv
// 8N1-style UART receiver driven by an N_TICKS-per-bit oversampling strobe.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote on data and stop bit samples.
module uart_receptor #(
  parameter int N_BITS  = 8,
  parameter int N_TICKS = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_rx,
  uart_receptor_if.master rxIf
);

  localparam int SW = $clog2(N_TICKS);
  localparam int NW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [SW-1:0] S_MID_START = SW'(N_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(N_TICKS - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     tickCnt_q, tickCnt_d;
  logic [NW-1:0]     bitCnt_q, bitCnt_d;
  logic [N_BITS-1:0] shiftBuf_q, shiftBuf_d;
  logic [N_BITS-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              frameErr_q, frameErr_d;
  logic              rxMeta_q, rxSync_q;
  logic              rx;
  logic              sampledBit;

  assign rx = rxSync_q;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= i_rx;
      rxSync_q <= rxMeta_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [SW-1:0] S_VOTE0 = SW'(N_TICKS - 3);
  localparam logic [SW-1:0] S_VOTE1 = SW'(N_TICKS - 2);

  logic vote0_q, vote0_d;
  logic vote1_q, vote1_d;

  // Two early samples are held; the third is the live line at the commit tick.
  always_comb begin
    vote0_d = vote0_q;
    vote1_d = vote1_q;
    if (i_s_tick && (state_q == DATA || state_q == STOP)) begin
      if (tickCnt_q == S_VOTE0) vote0_d = rx;
      if (tickCnt_q == S_VOTE1) vote1_d = rx;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      vote0_q <= 1'b0;
      vote1_q <= 1'b0;
    end else begin
      vote0_q <= vote0_d;
      vote1_q <= vote1_d;
    end
  end

  assign sampledBit = (vote0_q & vote1_q) | (vote0_q & rx) | (vote1_q & rx);
`else
  assign sampledBit = rx;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shiftBuf_q <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftBuf_q <= shiftBuf_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftBuf_d = shiftBuf_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    frameErr_d = frameErr_q;

    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d   = START;
          tickCnt_d = '0;
        end
      end

      // A start bit that is high again at its midpoint was only a glitch.
      START: begin
        if (i_s_tick) begin
          if (tickCnt_q == S_MID_START) begin
            if (!rx) begin
              state_d   = DATA;
              tickCnt_d = '0;
              bitCnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tickCnt_d = tickCnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (tickCnt_q == S_LAST) begin
            tickCnt_d  = '0;
            shiftBuf_d = {sampledBit, shiftBuf_q[N_BITS-1:1]};
            if (bitCnt_q == N_LAST) begin
              state_d  = STOP;
              bitCnt_d = '0;
            end else begin
              bitCnt_d = bitCnt_q + NW'(1);
            end
          end else begin
            tickCnt_d = tickCnt_q + SW'(1);
          end
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
      STOP: begin
        if (i_s_tick) begin
          if (tickCnt_q == S_LAST) begin
            tickCnt_d  = '0;
            done_d     = 1'b1;
            dout_d     = shiftBuf_q;
            frameErr_d = ~sampledBit;
            state_d    = sampledBit ? IDLE : BREAK;
          end else begin
            tickCnt_d = tickCnt_q + SW'(1);
          end
        end
      end

      BREAK: begin
        if (rx) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rxIf.o_dout         = dout_q;
  assign rxIf.o_rx_done_tick = done_q;
  assign rxIf.o_frame_error  = frameErr_q;

endmodule

// File: tb/tb_uart_receptor.sv
// Scoreboard bench for uart_receptor: frames are driven tick-aligned and expected words queued.
module tb_uart_receptor;

  localparam int N_BITS   = 8;
  localparam int N_TICKS  = 16;
  localparam int TICK_DIV = 4;

  typedef struct {
    logic [N_BITS-1:0] data;
    logic              fe;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sTick = 1'b0;
  logic rx    = 1'b1;

  exp_t expQ[$];
  int   checks     = 0;
  int   errors     = 0;
  int   pulseCount = 0;

  logic [N_BITS-1:0] modelDout = '0;
  logic              modelFe   = 1'b0;
  logic              prevDone  = 1'b0;

  uart_receptor_if #(.N_BITS(N_BITS)) rxIf ();

  uart_receptor #(
    .N_BITS (N_BITS),
    .N_TICKS(N_TICKS)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_s_tick(sTick),
    .i_rx    (rx),
    .rxIf    (rxIf)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 sTick = 1'b1;
      @(posedge clk);
      #1 sTick = 1'b0;
    end
  end

  // Each done pulse pops the oldest expected word; between pulses the outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      modelDout = '0;
      modelFe   = 1'b0;
      prevDone  = 1'b0;
    end else begin
      if (rxIf.o_rx_done_tick === 1'b1) begin
        pulseCount++;
        checks++;
        if (prevDone !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_width: done high %0d consecutive cycles, required 1", 2);
        end
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pulse: dout=%02h with empty scoreboard", rxIf.o_dout);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          modelDout = e.data;
          modelFe   = e.fe;
        end
      end
      checks++;
      if (rxIf.o_dout !== modelDout) begin
        errors++;
        $display("[TB] FAIL dout: got %02h expected %02h", rxIf.o_dout, modelDout);
      end
      checks++;
      if (rxIf.o_frame_error !== modelFe) begin
        errors++;
        $display("[TB] FAIL frame_error: got %b expected %b", rxIf.o_frame_error, modelFe);
      end
      prevDone = rxIf.o_rx_done_tick;
    end
  end

  task automatic waitTick();
    do @(posedge clk); while (sTick !== 1'b1);
  endtask

  task automatic idleTicks(input int n);
    repeat (n) waitTick();
    #1;
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    idleTicks(N_TICKS);
  endtask

  task automatic sendFrame(input logic [N_BITS-1:0] data, input logic stopBit);
    expQ.push_back('{data: data, fe: ~stopBit});
    driveBit(1'b0);
    for (int i = 0; i < N_BITS; i++) driveBit(data[i]);
    driveBit(stopBit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rxIf.o_dout !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %02h expected 00", rxIf.o_dout);
    end
    checks++;
    if (rxIf.o_rx_done_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected 0", rxIf.o_rx_done_tick);
    end
    checks++;
    if (rxIf.o_frame_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_fe: got %b expected 0", rxIf.o_frame_error);
    end
    rst_n = 1'b1;
    idleTicks(2);
  endtask

  task automatic test_single_frame();
    int p0;
    p0 = pulseCount;
    sendFrame(8'hA5, 1'b1);
    idleTicks(4);
    checks++;
    if (pulseCount - p0 != 1) begin
      errors++;
      $display("[TB] FAIL single_pulses: got %0d expected 1", pulseCount - p0);
    end
    checks++;
    if (rxIf.o_dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_dout: got %02h expected a5", rxIf.o_dout);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulseCount;
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    idleTicks(4);
    checks++;
    if (pulseCount - p0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulseCount - p0);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: %0d words never received, expected 0", expQ.size());
    end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulseCount;
    rx = 1'b0;
    idleTicks(4);
    rx = 1'b1;
    idleTicks(24);
    checks++;
    if (pulseCount - p0 != 0) begin
      errors++;
      $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulseCount - p0);
    end
    checks++;
    if (rxIf.o_dout !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL glitch_hold: got %02h expected ff", rxIf.o_dout);
    end
    sendFrame(8'h3C, 1'b1);
    idleTicks(4);
    checks++;
    if (rxIf.o_dout !== 8'h3C || pulseCount - p0 != 1) begin
      errors++;
      $display("[TB] FAIL glitch_next: got %02h/%0d pulses expected 3c/1", rxIf.o_dout, pulseCount - p0);
    end
  endtask

  task automatic test_break();
    int p0;
    p0 = pulseCount;
    sendFrame(8'h3C, 1'b0);
    idleTicks(40);
    checks++;
    if (pulseCount - p0 != 1) begin
      errors++;
      $display("[TB] FAIL break_pulses: got %0d expected 1", pulseCount - p0);
    end
    checks++;
    if (rxIf.o_frame_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_fe: got %b expected 1", rxIf.o_frame_error);
    end
    rx = 1'b1;
    idleTicks(N_TICKS);
    sendFrame(8'h81, 1'b1);
    idleTicks(4);
    checks++;
    if (pulseCount - p0 != 2 || rxIf.o_dout !== 8'h81 || rxIf.o_frame_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_recover: got %0d pulses dout %02h fe %b expected 2/81/0",
               pulseCount - p0, rxIf.o_dout, rxIf.o_frame_error);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [N_BITS-1:0] partial;
    int p0;
    partial = 8'hC3;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(partial[i]);
    rx = partial[4];
    idleTicks(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rxIf.o_dout !== '0 || rxIf.o_frame_error !== 1'b0 || rxIf.o_rx_done_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: dout %02h fe %b done %b expected 00/0/0",
               rxIf.o_dout, rxIf.o_frame_error, rxIf.o_rx_done_tick);
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    idleTicks(2);
    p0 = pulseCount;
    sendFrame(8'h5A, 1'b1);
    idleTicks(4);
    checks++;
    if (pulseCount - p0 != 1 || rxIf.o_dout !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL post_reset: got %0d pulses dout %02h expected 1/5a",
               pulseCount - p0, rxIf.o_dout);
    end
  endtask

  task automatic test_majority();
    logic [N_BITS-1:0] want;
    int p0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    want = 8'h00;
`else
    want = 8'h08;
`endif
    p0 = pulseCount;
    expQ.push_back('{data: want, fe: 1'b0});
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b0);
    rx = 1'b0;
    idleTicks(N_TICKS - 9);
    rx = 1'b1;
    idleTicks(1);
    rx = 1'b0;
    idleTicks(8);
    for (int i = 4; i < N_BITS; i++) driveBit(1'b0);
    driveBit(1'b1);
    idleTicks(4);
    checks++;
    if (pulseCount - p0 != 1 || rxIf.o_dout !== want) begin
      errors++;
      $display("[TB] FAIL vote_glitch: got %0d pulses dout %02h expected 1/%02h",
               pulseCount - p0, rxIf.o_dout, want);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_majority();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain: %0d words never received, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_receptor.md
Name: uart_receptor

Overview:
Serial-to-parallel UART receiver, the receive end of the UART transmitter's 8N1 link. It samples the asynchronous RX line using the shared N_TICKS-per-bit oversampling tick, finds each start bit, reassembles N_BITS data bits LSB first and checks the stop bit. It presents each byte with a one-cycle done pulse to the ALU command interface.

Parameters:
N_BITS, 8, data bits per frame; LSB received first.
N_TICKS, 16, i_s_tick pulses per bit period; must be even and at least 4.

Ports:
i_clock  input  1  system clock; all state updates on its rising edge.
i_reset  input  1  asynchronous, active-low reset; asserted when 0.
i_s_tick  input  1  one-clock-wide oversampling strobe from the baud generator.
i_rx  input  1  serial line; idle high; asynchronous to i_clock.
o_dout  output  N_BITS  last received data word; held until the next frame completes.
o_rx_done_tick  output  1  one-clock pulse when a frame completes.
o_frame_error  output  1  1 if the last completed frame's stop bit sampled 0; held until the next completion.

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, tick counter s=0, bit counter n=0, shift buffer=0, o_dout=0, o_rx_done_tick=0, o_frame_error=0, both synchronizer flops=1.
- i_rx passes through a 2-flop synchronizer, so internal rx lags the pin by 2 clocks. All decisions use the synchronized value.
- Counter widths: s is $clog2(N_TICKS) bits; n is $clog2(N_BITS) bits. n wraps to 0 when leaving DATA.
- IDLE: when rx=0, go to START with s=0. i_s_tick is ignored in IDLE.
- START: on each i_s_tick, s increments.
  - At s==N_TICKS/2-1 (mid start bit): if rx=0, go to DATA with s=0, n=0.
  - If rx=1 at that point, treat it as a glitch: return to IDLE with no output activity.
- DATA: on each i_s_tick, s increments.
  - At s==N_TICKS-1 (mid bit): set s=0 and shift the sampled bit in at the MSB (buffer={bit, buffer[N_BITS-1:1]}).
  - If n==N_BITS-1, go to STOP; otherwise n increments.
- STOP: at s==N_TICKS-1 (mid stop bit), on the clock after that i_s_tick edge:
  - o_rx_done_tick=1 for exactly one clock.
  - o_dout=buffer.
  - o_frame_error=~sampled_bit.
  - If the stop bit sampled 1, go to IDLE. If it sampled 0, go to BREAK.
- BREAK: wait for rx=1, then go to IDLE. While in BREAK, a low line never starts a frame.
- Done and error outputs are registered and update in the same clock. o_dout and o_frame_error do not change at any other time.
- Back-to-back frames: IDLE is entered at mid stop bit, so the next start edge, arriving half a bit later, is detected.
- i_s_tick is held high at most one clock per pulse; the block counts ticks, not clocks.
- No i_s_tick in STOP: the block stays in STOP indefinitely; no timeout.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: in DATA and STOP, rx is captured on the i_s_tick edges at s==N_TICKS-3, N_TICKS-2 and N_TICKS-1. The committed bit is the 2-of-3 majority of those samples. START validation is unchanged (single sample). Timing of o_rx_done_tick is unchanged.
- Undefined: single sample at s==N_TICKS-1. No vote registers are instantiated.

Test Plan:
1. Defaults, i_s_tick every 4 clocks; send 8N1 frame 0xA5 -> one o_rx_done_tick pulse, o_dout=0xA5, o_frame_error=0, state back to IDLE.
2. Frames 0x00 then 0xFF back to back, each with a 1-bit stop -> two done pulses; o_dout=0x00 then 0xFF; o_frame_error=0 both times.
3. Idle line pulsed low for 4 ticks (< N_TICKS/2) -> no done pulse; o_dout unchanged; next valid frame 0x3C received correctly.
4. Frame 0x3C with stop bit 0, line then held low for 40 ticks, then high, then frame 0x81 -> first done pulse with o_dout=0x3C and o_frame_error=1; no pulse while the line is held low; second pulse with o_dout=0x81 and o_frame_error=0.
5. i_reset driven low mid-DATA (after bit 3) -> all outputs 0 immediately, independent of i_clock; after release, frame 0x5A -> o_dout=0x5A with one pulse.
6. Frame 0x00 with a one-tick high glitch on i_rx covering the s==N_TICKS-1 sample of bit 3 -> with UART_RX_MAJORITY_VOTE_EN: o_dout=0x00; without it: o_dout=0x08.
